// File: rtl/count_ctrl_pkg.sv
// Shared FSM encodings for the run/pause/direction controller.
package count_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, stability filter and
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          live1;
  logic          live2;
  logic          armed;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // armed blocks a press from a button already held when reset was released;
  // it needs one released sample seen through the synchronizer first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      live1   <= 1'b0;
      live2   <= 1'b0;
      armed   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      live1   <= 1'b1;
      live2   <= live1;
      level_d <= level;
      press   <= level & ~level_d & armed;

      if (live2 && !sync2) begin
        armed <= 1'b1;
      end

      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/direction controller for the display counter: debounces three
// buttons and gates the 1 Hz tick into count-enable, direction and clear.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned CNT_MAX    = 9,
  parameter bit          WRAP       = 1'b1,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_run,
  input  logic               btn_dir,
  input  logic               btn_clr,
  input  logic [CNT_W-1:0]   count,
  output logic               cnt_en,
  output logic               up_down,
  output logic               cnt_clr,
  output logic [STATE_W-1:0] state,
  output logic               at_limit
);

  state_t state_q;
  logic   run_p;
  logic   dir_p;
  logic   clr_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst(rst), .btn(btn_run), .press(run_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk(clk), .rst(rst), .btn(btn_dir), .press(dir_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .press(clr_p)
  );

  assign at_limit = (up_down && (count == CNT_W'(CNT_MAX))) ||
                    (!up_down && (count == '0));

  // Built from registered state so a tick coinciding with a press still sees
  // the pre-press state and direction.
  assign cnt_en = tick && (state_q == ST_RUN) && (WRAP || !at_limit) && !cnt_clr;

  assign state = state_q;

  // Clear has priority; direction toggles alongside any run transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      up_down <= 1'b1;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      if (clr_p) begin
        state_q <= ST_IDLE;
        up_down <= 1'b1;
        cnt_clr <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_p) state_q <= ST_RUN;
            if (dir_p) up_down <= ~up_down;
          end
          ST_RUN: begin
            if (run_p) begin
              state_q <= ST_PAUSE;
            end else if (!WRAP && tick && at_limit) begin
              state_q <= ST_HOLD;
            end
            if (dir_p) up_down <= ~up_down;
          end
          ST_PAUSE: begin
            if (run_p) state_q <= ST_RUN;
            if (dir_p) up_down <= ~up_down;
          end
          ST_HOLD: begin
            if (dir_p) begin
              up_down <= ~up_down;
              state_q <= ST_PAUSE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: random-count stimulus against a
// sample-history reference model, one wrapping and one stopping instance.
module tb_count_ctrl;

  localparam int DEB  = 4;
  localparam int MAXE = 8192;
  localparam int BIG  = 1 << 30;

  typedef struct packed {
    logic [1:0] st;
    logic       ud;
    logic       clr;
    logic       en;
    logic       lim;
  } exp_t;

  typedef struct packed {
    exp_t w;
    exp_t s;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn_run;
  logic       btn_dir;
  logic       btn_clr;
  logic [3:0] count;

  logic       cnt_en  [2];
  logic       up_down [2];
  logic       cnt_clr [2];
  logic [1:0] st      [2];
  logic       at_limit[2];

  int errors = 0;
  int checks = 0;

  pair_t exp_q[$];

  count_ctrl #(.CNT_W(4), .CNT_MAX(9), .WRAP(1'b1), .DEB_CYCLES(DEB)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_clr(btn_clr), .count(count), .cnt_en(cnt_en[0]), .up_down(up_down[0]),
    .cnt_clr(cnt_clr[0]), .state(st[0]), .at_limit(at_limit[0])
  );

  count_ctrl #(.CNT_W(4), .CNT_MAX(9), .WRAP(1'b0), .DEB_CYCLES(DEB)) u_stop (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_dir(btn_dir),
    .btn_clr(btn_clr), .count(count), .cnt_en(cnt_en[1]), .up_down(up_down[1]),
    .cnt_clr(cnt_clr[1]), .state(st[1]), .at_limit(at_limit[1])
  );

  always #5 clk = ~clk;

  // Reference model: per-edge history of raw button samples since reset.
  bit   raw_h[3][MAXE];
  bit   db_h [3][MAXE];
  bit   p_h  [3][MAXE];
  int   rel_e[3];
  int   n;
  int   cyc = 0;
  logic [1:0] m_st [2];
  logic       m_ud [2];
  logic       m_clr[2];

  logic       c_rst;
  logic       c_tick;
  logic [2:0] c_btn;
  logic [3:0] c_cnt;

  function automatic bit synced(int b, int e);
    return (e >= 3) ? raw_h[b][e-2] : 1'b0;
  endfunction

  function automatic logic limit(logic ud, logic [3:0] c);
    return ud ? (c == 4'd9) : (c == 4'd0);
  endfunction

  task automatic model_reset();
    n = 0;
    for (int b = 0; b < 3; b++) begin
      db_h[b][0] = 1'b0;
      p_h[b][0]  = 1'b0;
      rel_e[b]   = BIG;
    end
    for (int d = 0; d < 2; d++) begin
      m_st[d]  = 2'd0;
      m_ud[d]  = 1'b1;
      m_clr[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit flip;
    bit rp, dp, cp, lim;
    if (!c_rst) return;
    if (n >= MAXE - 1) begin
      $display("FAIL model_capacity edges=%0d limit=%0d", n, MAXE - 1);
      errors++;
      return;
    end
    n++;
    for (int b = 0; b < 3; b++) begin
      raw_h[b][n] = c_btn[b];
      if (!c_btn[b] && rel_e[b] == BIG) rel_e[b] = n;
      // Level follows once DEB consecutive synced samples disagree with it.
      flip = (n >= DEB);
      for (int k = 0; k < DEB; k++)
        if (n - k >= 1 && synced(b, n - k) == db_h[b][n-1]) flip = 1'b0;
      db_h[b][n] = flip ? ~db_h[b][n-1] : db_h[b][n-1];
      p_h[b][n]  = (n >= 2) && db_h[b][n-1] && !db_h[b][n-2] && (rel_e[b] <= n - 3);
    end
    rp = p_h[0][n-1];
    dp = p_h[1][n-1];
    cp = p_h[2][n-1];
    for (int d = 0; d < 2; d++) begin
      lim = limit(m_ud[d], c_cnt);
      m_clr[d] = 1'b0;
      if (cp) begin
        m_st[d] = 2'd0; m_ud[d] = 1'b1; m_clr[d] = 1'b1;
      end else if (m_st[d] == 2'd3) begin
        if (dp) begin m_ud[d] = ~m_ud[d]; m_st[d] = 2'd2; end
      end else begin
        if (m_st[d] == 2'd0 && rp) m_st[d] = 2'd1;
        else if (m_st[d] == 2'd2 && rp) m_st[d] = 2'd1;
        else if (m_st[d] == 2'd1 && rp) m_st[d] = 2'd2;
        else if (m_st[d] == 2'd1 && d == 1 && c_tick && lim) m_st[d] = 2'd3;
        if (dp) m_ud[d] = ~m_ud[d];
      end
    end
  endtask

  function automatic exp_t expect_for(int d);
    exp_t e;
    e.st  = m_st[d];
    e.ud  = m_ud[d];
    e.clr = m_clr[d];
    e.lim = limit(m_ud[d], c_cnt);
    e.en  = c_tick && (m_st[d] == 2'd1) && (d == 0 || !e.lim) && !m_clr[d];
    return e;
  endfunction

  function automatic logic [3:0] pick_count();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return 4'd9;
    if (r < 7) return 4'd0;
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic step(input logic r, input logic [2:0] b);
    pair_t p;
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    c_rst  = r;
    c_btn  = b;
    c_tick = (cyc % 10 == 0);
    c_cnt  = pick_count();
    rst = c_rst; btn_run = b[0]; btn_dir = b[1]; btn_clr = b[2];
    tick = c_tick; count = c_cnt;
    if (!c_rst) model_reset();
    p.w = expect_for(0);
    p.s = expect_for(1);
    exp_q.push_back(p);
  endtask

  task automatic hold(input logic r, input logic [2:0] b, input int k);
    for (int i = 0; i < k; i++) step(r, b);
  endtask

  task automatic check(input string nm, input int d, input logic [3:0] act,
                       input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, d, $time, act, want);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the active edge.
  initial begin
    pair_t p;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          e = (d == 0) ? p.w : p.s;
          check("state",    d, {2'b00, st[d]},      {2'b00, e.st});
          check("up_down",  d, {3'b000, up_down[d]}, {3'b000, e.ud});
          check("cnt_clr",  d, {3'b000, cnt_clr[d]}, {3'b000, e.clr});
          check("cnt_en",   d, {3'b000, cnt_en[d]},  {3'b000, e.en});
          check("at_limit", d, {3'b000, at_limit[d]}, {3'b000, e.lim});
        end
      end
    end
  end

  initial begin
    rst = 1'b0; btn_run = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
    tick = 1'b0; count = 4'd0;
    c_rst = 1'b0; c_btn = 3'b000; c_tick = 1'b0; c_cnt = 4'd0;
    model_reset();

    hold(1'b0, 3'b000, 3);
    hold(1'b1, 3'b000, 5);
    hold(1'b1, 3'b001, 12);
    hold(1'b1, 3'b000, 30);
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 3'b001, 2);
      hold(1'b1, 3'b000, 2);
    end
    hold(1'b1, 3'b001, 10);
    hold(1'b1, 3'b000, 20);
    hold(1'b1, 3'b001, 3);
    hold(1'b1, 3'b000, 20);
    hold(1'b1, 3'b010, 8);
    hold(1'b1, 3'b000, 15);
    hold(1'b1, 3'b001, 8);
    hold(1'b1, 3'b000, 40);
    hold(1'b1, 3'b101, 8);
    hold(1'b1, 3'b000, 20);

    for (int i = 0; i < 150; i++) begin
      hold(1'b1, 3'($urandom_range(0, 7)), int'($urandom_range(1, 12)));
      hold(1'b1, 3'b000, int'($urandom_range(0, 20)));
    end

    hold(1'b1, 3'b001, 8);
    hold(1'b1, 3'b000, 30);
    hold(1'b1, 3'b001, 10);
    hold(1'b0, 3'b001, 3);
    hold(1'b1, 3'b001, 20);
    hold(1'b1, 3'b000, 10);
    hold(1'b1, 3'b001, 10);
    hold(1'b1, 3'b000, 20);

    @(negedge clk);
    #1;
    check("queue_drained", 0, (exp_q.size() == 0) ? 4'd0 : 4'd1, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Run/pause/direction controller for the 4-bit counter and seven-segment display path. It debounces three raw push buttons and sequences the counter through a 4-state FSM. It drives the counter's count-enable, direction and clear from the 1 Hz tick strobe, all in a single clock domain. It sits between the board buttons, the frequency divider's tick output and the counter.

Parameters:
CNT_W, 4, counter width.
CNT_MAX, 9, upper count limit (lower limit fixed at 0).
WRAP, 1, 1 = counter wraps at limits; 0 = stop (HOLD) at limits.
DEB_CYCLES, 1000000, clk cycles a button level must stay stable (20 ms at 50 MHz).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-low reset.
tick  in  1  1-cycle strobe from the frequency divider, clk domain.
btn_run  in  1  raw run/pause button, active-high, asynchronous.
btn_dir  in  1  raw direction-toggle button, active-high, asynchronous.
btn_clr  in  1  raw clear button, active-high, asynchronous.
count  in  CNT_W  current counter value.
cnt_en  out  1  1-cycle count-enable to the counter.
up_down  out  1  1 = up, 0 = down.
cnt_clr  out  1  1-cycle synchronous clear to the counter.
state  out  2  FSM state, for LEDs and debug.
at_limit  out  1  count is at the limit in the current direction.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, up_down=1, cnt_en=0, cnt_clr=0, all debounce state=0.
- at_limit is combinational: (up_down & count==CNT_MAX) | (~up_down & count==0).
- Per-button path:
  - 2-FF synchronizer.
  - Stability counter: the debounced level takes the synced level after DEB_CYCLES consecutive equal samples; the counter restarts on any change.
  - Press pulse = rising edge of the debounced level, 1 cycle wide.
  - Press latency from a stable raw level: 2 + DEB_CYCLES + 1 cycles.
  - Release edges generate nothing.
- FSM states: IDLE=0, RUN=1, PAUSE=2, HOLD=3.
  - IDLE: run_p -> RUN.
  - RUN: run_p -> PAUSE. If WRAP=0 and tick & at_limit -> HOLD.
  - PAUSE: run_p -> RUN.
  - HOLD: run_p ignored; dir_p toggles up_down and moves to PAUSE.
  - Any state: clr_p -> IDLE, cnt_clr=1 for exactly one cycle (next cycle), up_down forced to 1.
- Priority: clr_p over run_p and dir_p.
- run_p and dir_p in the same cycle (not HOLD): both take effect (transition plus toggle).
- dir_p in IDLE, RUN or PAUSE toggles up_down on the next edge.
- cnt_en = tick & (state==RUN) & (WRAP | ~at_limit).
  - Uses registered state and up_down, so a tick coinciding with a press still uses the pre-press state and direction.
  - Never more than 1 cycle wide.
  - Forced to 0 in any cycle where cnt_clr=1.
- WRAP=1: cnt_en is issued at limits; the counter performs the wrap (CNT_MAX->0 up, 0->CNT_MAX down).
- Reset asserted mid-operation returns all state and outputs to reset values immediately (asynchronous); a held button generates no press after reset until released and re-pressed.
- A tick arriving in IDLE, PAUSE or HOLD is discarded.

Decomposition:
- Shared package: state encodings (IDLE/RUN/PAUSE/HOLD) and the 2-bit state width constant.
- One sub-module, btn_debounce: synchronizer, stability counter and rising-edge pulse, parameterised by DEB_CYCLES. It is instantiated three times.
- The FSM and output logic stay in count_ctrl.

Test Plan:
(Sim: DEB_CYCLES=4, tick every 10 cycles.)
1. Reset, then hold btn_run high 12 cycles -> one run pulse 7 cycles after the rise; state 0->1; cnt_en pulses coincide with ticks only.
2. Bounce btn_run (toggle every 2 cycles for 10 cycles, then steady high) -> exactly one run pulse; a glitch shorter than 4 cycles -> no pulse.
3. RUN, up, WRAP=0, count=9 at tick -> cnt_en=0, state=3 next cycle; dir press -> up_down=0, state=2; run press -> state=1, next tick cnt_en=1.
4. RUN with WRAP=1, count=9, up -> cnt_en=1 at tick, state stays 1.
5. Clear and run pressed in the same cycle while in RUN, down -> cnt_clr=1 for one cycle, state=0, up_down=1, no cnt_en that cycle.
6. Assert rst mid-RUN with btn_run held -> outputs at reset values asynchronously; no run pulse after release of rst until btn_run falls and rises again.
